fdc_disk_responder: RTL and testbench

Image-side responder for the NEC765 floppy controller's host mailbox. It decodes the request fields the controller raises on `disk_sr` (seek, read sector, write sector, read ID) and services them against a byte-addressed disk-image RAM. Read data is streamed into the controller's input FIFO and write data is drained from its output FIFO. Completion and error are reported back on `disk_cr`. It replaces the external MCU loop in builds that keep the disk images in on-chip or SDRAM memory.

---
 rtl/fdc_disk_responder.sv | 218 +++++++++++++++++++++
 tb/tb_fdc_disk_responder.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdc_disk_responder.sv
// Disk-image responder for the NEC765 host mailbox: decodes seek / read-ID /
// read / write requests on disk_sr and services them against a byte-addressed image RAM.
module fdc_disk_responder #(
  parameter int TRACKS       = 40,
  parameter int SIDES        = 1,
  parameter int SPT          = 9,
  parameter int FIRST_SECTOR = 8'hC1,
  parameter int SEEK_CYCLES  = 16,
  parameter int ADDR_W       = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       disk_sr,
  output logic [31:0]       disk_cr,
  output logic [7:0]        disk_data_in,
  output logic              disk_data_clkin,
  input  logic [7:0]        disk_data_out,
  output logic              disk_data_clkout,
  input  logic [1:0]        drive_present,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEEK, S_RDID, S_RD, S_WR, S_DONE
  } state_t;

  localparam logic [15:0] XFER_LAST = 16'd1023;
  localparam logic [15:0] SEEK_LAST = 16'(SEEK_CYCLES - 1);
  localparam logic [7:0]  IDX_LAST  = 8'(SPT - 1);

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                drv_q, drv_d;
  logic                err_pend_q, err_pend_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                seek_a_q, seek_a_d;
  logic                seek_b_q, seek_b_d;
  logic [7:0]          rdid_q, rdid_d;
  logic [1:0][7:0]     idx_q, idx_d;
  logic [1:0]          present_q;

  logic [31:0] cyl_w, head_w, sec_w;
  logic        cyl_ok, chs_ok;
  logic        req_sk, req_id, req_rd, req_wr, req_any;
  logic        sel_drv;
  logic        unused_sr;

  assign unused_sr = ^{disk_sr[31:26], disk_sr[19], disk_sr[16]};

  // Linear image offset of the first byte of a sector; all drives share one image RAM.
  function automatic logic [ADDR_W-1:0] image_addr(input logic drv, input logic [31:0] cyl,
                                                    input logic [31:0] head, input logic [31:0] sec);
    logic [31:0] trk;
    logic [31:0] lin;
    trk = {31'd0, drv} * 32'(TRACKS * SIDES) + cyl * 32'(SIDES) + head;
    lin = (trk * 32'(SPT) + sec - 32'(FIRST_SECTOR)) << 9;
    return lin[ADDR_W-1:0];
  endfunction

  always_comb begin
    cyl_w   = {25'd0, disk_sr[14:8]};
    head_w  = {31'd0, disk_sr[15]};
    sec_w   = {24'd0, disk_sr[7:0]};
    cyl_ok  = cyl_w < 32'(TRACKS);
    chs_ok  = cyl_ok && (head_w < 32'(SIDES)) && (sec_w >= 32'(FIRST_SECTOR)) &&
              (sec_w < 32'(FIRST_SECTOR + SPT));
    req_rd  = |disk_sr[18:17];
    req_wr  = |disk_sr[21:20];
    req_id  = |disk_sr[23:22];
    req_sk  = |disk_sr[25:24];
    req_any = req_rd | req_wr | req_id | req_sk;
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    base_d           = base_q;
    drv_d            = drv_q;
    err_pend_d       = err_pend_q;
    err_d            = err_q;
    done_d           = done_q;
    seek_a_d         = seek_a_q;
    seek_b_d         = seek_b_q;
    rdid_d           = rdid_q;
    idx_d            = idx_q;
    sel_drv          = 1'b0;
    mem_rd           = 1'b0;
    mem_wr           = 1'b0;
    mem_wdata        = 8'd0;
    mem_addr         = '0;
    disk_data_in     = 8'd0;
    disk_data_clkin  = 1'b0;
    disk_data_clkout = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req_sk) begin
          sel_drv    = disk_sr[25];
          drv_d      = sel_drv;
          err_pend_d = !drive_present[sel_drv] || !cyl_ok;
          state_d    = S_SEEK;
        end else if (req_id) begin
          sel_drv    = disk_sr[23];
          drv_d      = sel_drv;
          err_pend_d = !drive_present[sel_drv];
          state_d    = S_RDID;
        end else if (req_rd || req_wr) begin
          sel_drv = req_rd ? disk_sr[18] : disk_sr[21];
          drv_d   = sel_drv;
          base_d  = image_addr(sel_drv, cyl_w, head_w, sec_w);
          if (!drive_present[sel_drv] || !chs_ok) begin
            // Rejected transfers report straight away without touching the FIFOs.
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = req_rd ? S_RD : S_WR;
          end
        end
      end
      S_SEEK: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == SEEK_LAST) begin
          err_d    = err_pend_q;
          seek_a_d = !drv_q;
          seek_b_d = drv_q;
          state_d  = S_DONE;
        end
      end
      S_RDID: begin
        done_d  = 1'b1;
        err_d   = err_pend_q;
        state_d = S_DONE;
        if (!err_pend_q) begin
          rdid_d       = 8'(FIRST_SECTOR) + idx_q[drv_q];
          idx_d[drv_q] = (idx_q[drv_q] == IDX_LAST) ? 8'd0 : idx_q[drv_q] + 8'd1;
        end
      end
      S_RD: begin
        // Even cycles fetch, odd cycles forward the byte fetched one cycle earlier.
        mem_addr        = base_q + ADDR_W'(cnt_q[9:1]);
        mem_rd          = !cnt_q[0];
        disk_data_clkin = cnt_q[0];
        disk_data_in    = cnt_q[0] ? mem_rdata : 8'd0;
        cnt_d           = cnt_q + 16'd1;
        if (cnt_q == XFER_LAST) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WR: begin
        mem_addr         = base_q + ADDR_W'(cnt_q[9:1]);
        mem_wr           = !cnt_q[0];
        disk_data_clkout = !cnt_q[0];
        mem_wdata        = cnt_q[0] ? 8'd0 : disk_data_out;
        cnt_d            = cnt_q + 16'd1;
        if (cnt_q == XFER_LAST) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!req_any) begin
          done_d   = 1'b0;
          err_d    = 1'b0;
          seek_a_d = 1'b0;
          seek_b_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      drv_q      <= 1'b0;
      err_pend_q <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      seek_a_q   <= 1'b0;
      seek_b_q   <= 1'b0;
      rdid_q     <= 8'd0;
      idx_q      <= '0;
      present_q  <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drv_q      <= drv_d;
      err_pend_q <= err_pend_d;
      err_q      <= err_d;
      done_q     <= done_d;
      seek_a_q   <= seek_a_d;
      seek_b_q   <= seek_b_d;
      rdid_q     <= rdid_d;
      idx_q      <= idx_d;
      present_q  <= drive_present;
    end
  end

  always_ff @(posedge clk) begin
    base_q <= base_d;
  end

  assign disk_cr = {rdid_q, 17'd0, present_q, done_q, err_q, 1'b0, seek_b_q, seek_a_q};
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_fdc_disk_responder.sv
// Bench for fdc_disk_responder: image RAM and write-FIFO models plus scenario tasks
// that compare observed strobes, bytes and disk_cr against bench-computed expectations.
module tb_fdc_disk_responder;
  localparam int ADDR_W = 20;
  localparam int RBASE  = (2 * 9 + 2) * 512;
  localparam int WBASE  = (1 * 360 + 39 * 9 + 8) * 512;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       disk_sr;
  logic [31:0]       disk_cr;
  logic [7:0]        disk_data_in;
  logic              disk_data_clkin;
  logic [7:0]        disk_data_out;
  logic              disk_data_clkout;
  logic [1:0]        drive_present;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;
  logic              mem_wr;
  logic [7:0]        mem_wdata;
  logic              busy;

  fdc_disk_responder dut (
    .clk(clk), .rst(rst), .disk_sr(disk_sr), .disk_cr(disk_cr),
    .disk_data_in(disk_data_in), .disk_data_clkin(disk_data_clkin),
    .disk_data_out(disk_data_out), .disk_data_clkout(disk_data_clkout),
    .drive_present(drive_present), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:(1<<ADDR_W)-1];
  logic [7:0] wfifo [0:511];
  logic [9:0] rd_ptr;
  logic       init_mode;
  logic       fifo_clr;

  // Image RAM: byte = address LSBs, with a marker band around the write target.
  always @(posedge clk) begin
    if (init_mode) begin
      for (int i = 0; i < (1 << ADDR_W); i++) begin
        if (i >= WBASE - 1 && i <= WBASE + 512) mem[i] = 8'hEE;
        else mem[i] = 8'(i);
      end
    end
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_wr) mem[mem_addr] = mem_wdata;
    if (fifo_clr) rd_ptr <= 10'd0;
    else if (disk_data_clkout) rd_ptr <= rd_ptr + 10'd1;
  end

  assign disk_data_out = wfifo[rd_ptr[8:0]];

  int checks = 0;
  int errors = 0;
  int n_in, n_out, first_in, done_cyc, b2b;
  logic [31:0] done_cr;
  logic [7:0]  got_q [$];
  logic [7:0]  exp_q [$];
  logic [ADDR_W-1:0] raddr_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise a request and record everything the DUT does until a done/seek bit, a byte limit or the cycle limit.
  task automatic do_cmd(input logic [31:0] sr, input int limit, input int stop_after);
    logic pin, pout;
    n_in = 0; n_out = 0; first_in = -1; done_cyc = -1; b2b = 0; done_cr = 32'd0;
    got_q.delete(); raddr_q.delete();
    pin = 1'b0; pout = 1'b0;
    disk_sr = sr;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      tick();
      if (disk_data_clkin) begin
        got_q.push_back(disk_data_in);
        n_in++;
        if (first_in < 0) first_in = cyc;
        if (pin) b2b++;
      end
      if (disk_data_clkout) begin
        n_out++;
        if (pout) b2b++;
      end
      if (mem_rd) raddr_q.push_back(mem_addr);
      pin  = disk_data_clkin;
      pout = disk_data_clkout;
      if (disk_cr[4] || disk_cr[1] || disk_cr[0]) begin
        done_cyc = cyc;
        done_cr  = disk_cr;
        break;
      end
      if (stop_after > 0 && n_in == stop_after) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; disk_sr = 32'd0; drive_present = 2'b00;
    init_mode = 1'b1; fifo_clr = 1'b1;
    tick();
    init_mode = 1'b0;
    repeat (2) tick();
    fifo_clr = 1'b0;
    checks++;
    if (disk_cr !== 32'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_cr: cr=%h busy=%b, want cr=0 busy=0", disk_cr, busy);
    end
    checks++;
    if ({disk_data_clkin, disk_data_clkout, mem_rd, mem_wr} !== 4'b0 || mem_addr !== '0) begin
      errors++; $display("FAIL reset_strobes: strobes=%b addr=%h, want 0", {disk_data_clkin, disk_data_clkout, mem_rd, mem_wr}, mem_addr);
    end
    rst = 1'b0; drive_present = 2'b11;
    repeat (2) tick();
    checks++;
    if (disk_cr !== 32'h0000_0060) begin
      errors++; $display("FAIL present_bits: cr=%h, want 00000060", disk_cr);
    end
  endtask

  task automatic test_seek();
    do_cmd((32'd1 << 24) | (32'd12 << 8), 100, 0);
    checks++;
    if (done_cyc !== 17) begin
      errors++; $display("FAIL seek_latency: got %0d cycles, want 17", done_cyc);
    end
    checks++;
    if ({done_cr[4], done_cr[3], done_cr[1], done_cr[0]} !== 4'b0001) begin
      errors++; $display("FAIL seek_bits: cr=%h, want [0]=1 others 0", done_cr);
    end
    repeat (3) tick();
    checks++;
    if (disk_cr[0] !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL seek_hold: cr0=%b busy=%b, want 1 1", disk_cr[0], busy);
    end
    disk_sr = 32'd0;
    tick();
    checks++;
    if (disk_cr[0] !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL seek_clear: cr0=%b busy=%b, want 0 0", disk_cr[0], busy);
    end
  endtask

  task automatic test_read();
    for (int i = 0; i < 512; i++) exp_q.push_back(8'(RBASE + i));
    do_cmd((32'd1 << 17) | (32'd2 << 8) | 32'hC3, 1200, 0);
    checks++;
    if (first_in !== 2 || n_in !== 512 || done_cyc !== 1025) begin
      errors++; $display("FAIL read_timing: first=%0d n=%0d done=%0d, want 2 512 1025", first_in, n_in, done_cyc);
    end
    checks++;
    if (done_cr[4] !== 1'b1 || done_cr[3] !== 1'b0 || b2b !== 0) begin
      errors++; $display("FAIL read_status: cr=%h b2b=%0d, want [4]=1 [3]=0 b2b=0", done_cr, b2b);
    end
    checks++;
    if (raddr_q.size() != 512 || raddr_q[0] !== ADDR_W'(RBASE) || raddr_q[511] !== ADDR_W'(RBASE + 511)) begin
      errors++; $display("FAIL read_addr: reads=%0d, want 512 reads from %0d", raddr_q.size(), RBASE);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL read_byte[%0d]: got %h, want %h", i, g, e);
      end
    end
    disk_sr = 32'd0;
    tick();
    checks++;
    if (disk_cr[4] !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL read_ack: cr4=%b busy=%b, want 0 0", disk_cr[4], busy);
    end
  endtask

  task automatic test_write();
    for (int i = 0; i < 512; i++) exp_q.push_back(8'(i));
    do_cmd((32'd1 << 21) | (32'd39 << 8) | 32'hC9, 1200, 0);
    checks++;
    if (done_cyc !== 1025 || n_out !== 512 || n_in !== 0 || b2b !== 0) begin
      errors++; $display("FAIL write_timing: done=%0d pops=%0d in=%0d b2b=%0d, want 1025 512 0 0", done_cyc, n_out, n_in, b2b);
    end
    checks++;
    if (done_cr[4] !== 1'b1 || done_cr[3] !== 1'b0) begin
      errors++; $display("FAIL write_status: cr=%h, want [4]=1 [3]=0", done_cr);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      checks++;
      if (mem[WBASE + i] !== e) begin
        errors++; $display("FAIL write_byte[%0d]: got %h, want %h", i, mem[WBASE + i], e);
      end
    end
    checks++;
    if (mem[WBASE - 1] !== 8'hEE || mem[WBASE + 512] !== 8'hEE) begin
      errors++; $display("FAIL write_bounds: below=%h above=%h, want ee ee", mem[WBASE - 1], mem[WBASE + 512]);
    end
    disk_sr = 32'd0;
    tick();
  endtask

  task automatic test_errors();
    do_cmd((32'd1 << 17) | (32'd2 << 8) | 32'hCA, 100, 0);
    checks++;
    if ({done_cr[4], done_cr[3]} !== 2'b11 || n_in !== 0 || raddr_q.size() != 0) begin
      errors++; $display("FAIL err_sector: cr=%h strobes=%0d reads=%0d, want [4]=1 [3]=1 0 0", done_cr, n_in, raddr_q.size());
    end
    disk_sr = 32'd0;
    tick();
    checks++;
    if (disk_cr[3] !== 1'b0 || disk_cr[4] !== 1'b0) begin
      errors++; $display("FAIL err_clear: cr=%h, want [4]=0 [3]=0", disk_cr);
    end
    drive_present = 2'b10;
    repeat (2) tick();
    do_cmd((32'd1 << 17) | (32'd2 << 8) | 32'hC3, 100, 0);
    checks++;
    if ({done_cr[4], done_cr[3]} !== 2'b11 || n_in !== 0 || raddr_q.size() != 0) begin
      errors++; $display("FAIL err_absent: cr=%h strobes=%0d reads=%0d, want [4]=1 [3]=1 0 0", done_cr, n_in, raddr_q.size());
    end
    drive_present = 2'b11;
    disk_sr = 32'd0;
    repeat (2) tick();
  endtask

  task automatic test_read_id();
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(8'hC1 + 8'(i % 9));
      do_cmd(32'd1 << 22, 20, 0);
      checks++;
      if (done_cr[31:24] !== exp_q[0] || done_cr[3] !== 1'b0 || done_cyc < 0) begin
        errors++; $display("FAIL read_id[%0d]: id=%h err=%b, want %h 0", i, done_cr[31:24], done_cr[3], exp_q[0]);
      end
      void'(exp_q.pop_front());
      disk_sr = 32'd0;
      tick();
    end
    checks++;
    if (disk_cr[31:24] !== 8'hC1) begin
      errors++; $display("FAIL read_id_hold: id=%h, want c1", disk_cr[31:24]);
    end
  endtask

  task automatic test_reset_mid_read();
    int late;
    do_cmd(32'd1 << 17 | 32'hC1, 1200, 100);
    checks++;
    if (n_in !== 100) begin
      errors++; $display("FAIL abort_setup: strobes=%0d, want 100", n_in);
    end
    rst = 1'b1; disk_sr = 32'd0;
    tick();
    checks++;
    if (disk_cr !== 32'd0 || disk_data_clkin !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_reset: cr=%h clkin=%b busy=%b, want 0 0 0", disk_cr, disk_data_clkin, busy);
    end
    rst = 1'b0;
    late = 0;
    repeat (10) begin
      tick();
      if (disk_data_clkin || mem_rd) late++;
    end
    checks++;
    if (late !== 0) begin
      errors++; $display("FAIL abort_quiet: strobes=%0d, want 0", late);
    end
    for (int i = 0; i < 512; i++) exp_q.push_back(8'(i));
    do_cmd(32'd1 << 17 | 32'hC1, 1200, 0);
    checks++;
    if (first_in !== 2 || n_in !== 512 || done_cyc !== 1025 || done_cr[3] !== 1'b0) begin
      errors++; $display("FAIL reread: first=%0d n=%0d done=%0d err=%b, want 2 512 1025 0", first_in, n_in, done_cyc, done_cr[3]);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [7:0] e, g;
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++;
      if (g !== e) begin
        errors++; $display("FAIL reread_byte[%0d]: got %h, want %h", i, g, e);
      end
    end
    disk_sr = 32'd0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) wfifo[i] = 8'(i);
    test_reset();
    test_seek();
    test_read();
    test_write();
    test_errors();
    test_read_id();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
